// File: rtl/xvga_scan_timing.sv
// 1024x768@60 raster timing generator and pipeline-aligned VGA output stage.
// Latency: hcount/vcount/sync/blank are registered together; vga_* trail the coordinates by PIPE_DELAY+1 clocks.
// Backpressure: none; the raster free-runs and pixel_in is sampled every clock.
module xvga_scan_timing #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter int PIPE_DELAY = 1
) (
  input  logic        vclock,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  input  logic [23:0] pixel_in,
  output logic [23:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0 of the delay line is the raw {hsync, vsync, blank} register
  // itself, so the tap at PIPE_DELAY lines up with the coordinates that
  // pixel_in currently represents.
  localparam logic [2:0] RAW_RST  = 3'b110;
  localparam logic [2:0] IDLE_SIG = 3'b111;

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        frame_start_q, frame_start_d;
  logic [2:0]  raw_d;
  logic [2:0]  dly_q [0:PIPE_DELAY];
  logic [2:0]  tap;
  logic [23:0] vga_rgb_q;
  logic        vga_hsync_q, vga_vsync_q, vga_blank_q;

  // Next raster position; frame_start flags the wrap from the last pixel back to (0,0).
  always_comb begin
    hcount_d      = hcount_q + 11'd1;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      if (vcount_q == V_LAST) begin
        vcount_d      = '0;
        frame_start_d = 1'b1;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end
  end

  // Raw sync/blank decoded from the next position so they register in step with the counters.
  always_comb begin
    raw_d    = IDLE_SIG;
    raw_d[2] = !((hcount_d >= HS_BEG) && (hcount_d < HS_END));
    raw_d[1] = !((vcount_d >= VS_BEG) && (vcount_d < VS_END));
    raw_d[0] = (hcount_d >= H_ACT) || (vcount_d >= V_ACT);
  end

  // Raster counters, raw timing register and sync/blank delay line.
  always_ff @(posedge vclock) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
      dly_q[0]      <= RAW_RST;
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        dly_q[i] <= IDLE_SIG;
      end
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
      dly_q[0]      <= raw_d;
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign tap = dly_q[PIPE_DELAY];

  // Output register: colour is forced black whenever the matching blank is set.
  always_ff @(posedge vclock) begin
    if (reset) begin
      vga_rgb_q   <= '0;
      vga_hsync_q <= 1'b1;
      vga_vsync_q <= 1'b1;
      vga_blank_q <= 1'b1;
    end else begin
      vga_rgb_q   <= tap[0] ? 24'h000000 : pixel_in;
      vga_hsync_q <= tap[2];
      vga_vsync_q <= tap[1];
      vga_blank_q <= tap[0];
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = dly_q[0][2];
  assign vsync       = dly_q[0][1];
  assign blank       = dly_q[0][0];
  assign frame_start = frame_start_q;
  assign vga_rgb     = vga_rgb_q;
  assign vga_hsync   = vga_hsync_q;
  assign vga_vsync   = vga_vsync_q;
  assign vga_blank   = vga_blank_q;

endmodule

// File: tb/tb_xvga_scan_timing.sv
// Bench for xvga_scan_timing: one full-size instance plus two shrunken rasters
// (PIPE_DELAY 0 and 3) so whole frames fit in a short run.
// Expected outputs come from a cycle-count model of the raster rules.
module tb_xvga_scan_timing;

  logic vclock = 1'b0;
  always #5 vclock = ~vclock;

  logic        rst;
  logic [23:0] pix_f, pix_0, pix_3;

  logic [10:0] f_hc, f_vc, a_hc, a_vc, b_hc, b_vc;
  logic        f_hs, f_vs, f_bl, f_fs, a_hs, a_vs, a_bl, a_fs, b_hs, b_vs, b_bl, b_fs;
  logic [23:0] f_rgb, a_rgb, b_rgb;
  logic        f_vhs, f_vvs, f_vbl, a_vhs, a_vvs, a_vbl, b_vhs, b_vvs, b_vbl;

  xvga_scan_timing u_full (
    .vclock(vclock), .reset(rst), .hcount(f_hc), .vcount(f_vc), .hsync(f_hs), .vsync(f_vs),
    .blank(f_bl), .frame_start(f_fs), .pixel_in(pix_f), .vga_rgb(f_rgb),
    .vga_hsync(f_vhs), .vga_vsync(f_vvs), .vga_blank(f_vbl)
  );

  xvga_scan_timing #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(12),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(5), .PIPE_DELAY(0)
  ) u_pd0 (
    .vclock(vclock), .reset(rst), .hcount(a_hc), .vcount(a_vc), .hsync(a_hs), .vsync(a_vs),
    .blank(a_bl), .frame_start(a_fs), .pixel_in(pix_0), .vga_rgb(a_rgb),
    .vga_hsync(a_vhs), .vga_vsync(a_vvs), .vga_blank(a_vbl)
  );

  xvga_scan_timing #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(12),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(5), .PIPE_DELAY(3)
  ) u_pd3 (
    .vclock(vclock), .reset(rst), .hcount(b_hc), .vcount(b_vc), .hsync(b_hs), .vsync(b_vs),
    .blank(b_bl), .frame_start(b_fs), .pixel_in(pix_3), .vga_rgb(b_rgb),
    .vga_hsync(b_vhs), .vga_vsync(b_vvs), .vga_blank(b_vbl)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n       = 0;      // clocks counted since the most recent reset edge
  bit chk_en  = 1'b0;
  bit phase_a = 1'b0;
  int fs_cnt_a, fs_cnt_f, hs_low_f;
  logic [23:0] prev_f, prev_0, prev_3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (n=%0d)", nm, act, exp, n);
  endtask

  // Raster state t clocks after reset, straight from the timing rules.
  function automatic void raster(input int t, input int ha, hf, hs, hb, va, vf, vs, vb,
                                 output int h, output int v, output bit hsy, output bit vsy,
                                 output bit bl, output bit fs);
    int ht, vt;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    h   = t % ht;
    v   = (t / ht) % vt;
    hsy = !(h >= ha + hf && h < ha + hf + hs);
    vsy = !(v >= va + vf && v < va + vf + vs);
    bl  = (h >= ha) || (v >= va);
    fs  = (t > 0) && (t % (ht * vt) == 0);
  endfunction

  // Renderer stand-in: colour for the coordinates PIPE_DELAY clocks back, white box on lo..hi.
  function automatic logic [23:0] pix_for(input int t, input int pd, input int ht, input int lo, input int hi);
    int h;
    logic [31:0] r;
    r = $urandom;
    if (t - pd < 0) return r[23:0];
    h = (t - pd) % ht;
    if (h >= lo && h <= hi) return 24'hFFFFFF;
    return {8'h00, r[15:0]};
  endfunction

  task automatic check_inst(input string tg, input int pd, input int ha, hf, hs, hb, va, vf, vs, vb,
                            input logic [23:0] ppix, input logic [10:0] hc, vc,
                            input logic hsy, vsy, bl, fs, input logic [23:0] rgb,
                            input logic vhs, vvs, vbl);
    int eh, ev, dh, dv;
    bit ehs, evs, ebl, efs, dhs, dvs, dbl, dfs;
    logic [23:0] ergb;
    raster(n, ha, hf, hs, hb, va, vf, vs, vb, eh, ev, ehs, evs, ebl, efs);
    chk({tg, ".hcount"}, 32'(hc), 32'(eh));
    chk({tg, ".vcount"}, 32'(vc), 32'(ev));
    chk({tg, ".hsync"}, 32'(hsy), 32'(ehs));
    chk({tg, ".vsync"}, 32'(vsy), 32'(evs));
    chk({tg, ".blank"}, 32'(bl), 32'(ebl));
    chk({tg, ".frame_start"}, 32'(fs), 32'(efs));
    if (n < pd + 1) begin
      dhs = 1'b1; dvs = 1'b1; dbl = 1'b1; ergb = 24'h0;
    end else begin
      raster(n - pd - 1, ha, hf, hs, hb, va, vf, vs, vb, dh, dv, dhs, dvs, dbl, dfs);
      ergb = dbl ? 24'h0 : ppix;
    end
    chk({tg, ".vga_rgb"}, 32'(rgb), 32'(ergb));
    chk({tg, ".vga_hsync"}, 32'(vhs), 32'(dhs));
    chk({tg, ".vga_vsync"}, 32'(vvs), 32'(dvs));
    chk({tg, ".vga_blank"}, 32'(vbl), 32'(dbl));
  endtask

  // Model clock: count clocks since reset and remember the colour each DUT just sampled.
  always @(posedge vclock) begin
    if (rst) n = 0;
    else     n = n + 1;
    prev_f = pix_f;
    prev_0 = pix_0;
    prev_3 = pix_3;
    chk_en = 1'b1;
  end

  // Compare process: model against every instance each cycle, plus literal pins.
  always @(negedge vclock) begin
    if (chk_en) begin
      check_inst("full", 1, 1024, 24, 136, 160, 768, 3, 6, 29, prev_f, f_hc, f_vc,
                 f_hs, f_vs, f_bl, f_fs, f_rgb, f_vhs, f_vvs, f_vbl);
      check_inst("pd0", 0, 40, 4, 8, 12, 20, 2, 3, 5, prev_0, a_hc, a_vc,
                 a_hs, a_vs, a_bl, a_fs, a_rgb, a_vhs, a_vvs, a_vbl);
      check_inst("pd3", 3, 40, 4, 8, 12, 20, 2, 3, 5, prev_3, b_hc, b_vc,
                 b_hs, b_vs, b_bl, b_fs, b_rgb, b_vhs, b_vvs, b_vbl);
      if (phase_a) begin
        if (a_fs) fs_cnt_a++;
        if (f_fs) fs_cnt_f++;
        if (n < 1344 && !f_hs) hs_low_f++;
      end
      case (n)
        1023: chk("pin.blank_1023", 32'(f_bl), 32'd0);
        1024: chk("pin.blank_1024", 32'(f_bl), 32'd1);
        1047: chk("pin.hsync_1047", 32'(f_hs), 32'd1);
        1048: chk("pin.hsync_1048", 32'(f_hs), 32'd0);
        1183: chk("pin.hsync_1183", 32'(f_hs), 32'd0);
        1184: chk("pin.hsync_1184", 32'(f_hs), 32'd1);
        1343: chk("pin.h_1343", {f_vc, 5'd0, f_hc}, {11'd0, 5'd0, 11'd1343});
        1344: chk("pin.v_step", {f_vc, 5'd0, f_hc}, {11'd1, 5'd0, 11'd0});
        66:   chk("pin.box_64", 32'(f_rgb), 32'hFFFFFF);
        82:   chk("pin.box_80", 32'(f_rgb), 32'hFFFFFF);
        83:   chk("pin.box_81", 32'(f_rgb == 24'hFFFFFF), 32'd0);
        1255: chk("pin.s_blank", 32'(a_bl), 32'd0);
        1407: chk("pin.s_vsync_1407", 32'(a_vs), 32'd1);
        1408: chk("pin.s_vsync_1408", 32'(a_vs), 32'd0);
        1599: chk("pin.s_vsync_1599", 32'(a_vs), 32'd0);
        1600: chk("pin.s_vsync_1600", 32'(a_vs), 32'd1);
        1920: chk("pin.s_frame", {a_vc, 4'd0, a_hc, 5'd0, a_fs}, {11'd0, 4'd0, 11'd0, 5'd0, 1'b1});
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge vclock);
    #2;
    pix_f = pix_for(n, 1, 1344, 64, 80);
    pix_0 = pix_for(n, 0, 64, 10, 16);
    pix_3 = pix_for(n, 3, 64, 10, 16);
  endtask

  initial begin
    int len;
    int k;
    rst   = 1'b1;
    pix_f = '0;
    pix_0 = '0;
    pix_3 = '0;
    fs_cnt_a = 0;
    fs_cnt_f = 0;
    hs_low_f = 0;
    repeat (5) step();
    rst     = 1'b0;
    phase_a = 1'b1;
    // Long free run: three full-size lines, a bit over two shrunken frames.
    repeat (4200) step();
    phase_a = 1'b0;
    chk("frame_start_count_small", 32'(fs_cnt_a), 32'd2);
    chk("frame_start_count_full", 32'(fs_cnt_f), 32'd0);
    chk("hsync_low_width", 32'(hs_low_f), 32'd136);
    // Random mid-raster resets of one or two clocks.
    repeat (6) begin
      len = $urandom_range(50, 900);
      repeat (len) step();
      rst = 1'b1;
      k = $urandom_range(1, 2);
      repeat (k) step();
      rst = 1'b0;
    end
    repeat (2500) step();
    @(negedge vclock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
